deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deser_pkg.sv | 19 +
 rtl/deser_comma_det.sv | 14 +
 rtl/deserializer.sv | 156 +++++++++++++++
 tb/tb_deserializer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/deser_pkg.sv
// Shared constants, state encoding and the K28.5 match helper for the 8b/10b word deserializer.
package deser_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] K28_5_RDN = 10'h17C;
    localparam logic [WORD_W-1:0] K28_5_RDP = 10'h283;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Either running-disparity form of K28.5 counts as a comma.
    function automatic logic is_k28_5(input logic [WORD_W-1:0] word);
        return (word == K28_5_RDN) || (word == K28_5_RDP);
    endfunction

endpackage

// File: rtl/deser_comma_det.sv
// Combinational K28.5 comma recogniser applied to a 10-bit candidate window.
module deser_comma_det
    import deser_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    output logic              is_comma
);

    // Pure compare against both disparity forms.
    always_comb begin
        is_comma = is_k28_5(word);
    end

endmodule

// File: rtl/deserializer.sv
// LSB-first 10-bit deserializer with K28.5 comma alignment.
// Optional in-lock realignment on off-grid commas is enabled by defining DESER_REALIGN_EN.
module deserializer
    import deser_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              serial_in,
    input  logic              valid_in,
    input  logic              lock_clr,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              locked,
    output logic              comma_det,
    output logic              realign
);

    localparam logic [3:0] LAST_BIT = 4'd9;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WORD_W-1:0] window_r;
    logic [WORD_W-1:0] window_nxt_s;
    logic [WORD_W-1:0] next_window_s;
    logic [3:0]        bit_cnt_r;
    logic [3:0]        bit_cnt_nxt_s;
    logic              is_comma_s;
    logic              emit_s;
    logic              realign_s;
    logic [WORD_W-1:0] data_out_r;
    logic              data_valid_r;
    logic              comma_det_r;
    logic              realign_r;

    // Candidate window as it would look after accepting the current bit.
    assign next_window_s = {serial_in, window_r[WORD_W-1:1]};

    deser_comma_det u_comma_det (
        .word     (next_window_s),
        .is_comma (is_comma_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; lock_clr overrides any accepted bit.
    always_comb begin
        state_nxt_s = state_r;
        if (lock_clr) begin
            state_nxt_s = HUNT;
        end else if (valid_in) begin
            case (state_r)
                HUNT: begin
                    if (is_comma_s) begin
                        state_nxt_s = LOCKED;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                LOCKED:  state_nxt_s = LOCKED;
                default: state_nxt_s = HUNT;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output/datapath decode: decides window/count updates and word emission.
    always_comb begin
        window_nxt_s  = window_r;
        bit_cnt_nxt_s = bit_cnt_r;
        emit_s        = 1'b0;
        realign_s     = 1'b0;
        if (lock_clr) begin
            window_nxt_s  = '0;
            bit_cnt_nxt_s = 4'd0;
        end else if (valid_in) begin
            window_nxt_s = next_window_s;
            case (state_r)
                HUNT: begin
                    bit_cnt_nxt_s = 4'd0;
                    if (is_comma_s) begin
                        emit_s = 1'b1;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                LOCKED: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        emit_s        = 1'b1;
                        bit_cnt_nxt_s = 4'd0;
                    end
`ifdef DESER_REALIGN_EN
                    else if (is_comma_s) begin
                        emit_s        = 1'b1;
                        realign_s     = 1'b1;
                        bit_cnt_nxt_s = 4'd0;
                    end
`endif
                    else begin
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    bit_cnt_nxt_s = 4'd0;
                end
            endcase
        end else begin
            window_nxt_s  = window_r;
            bit_cnt_nxt_s = bit_cnt_r;
        end
    end

    // Shift window and bit counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window_r  <= '0;
            bit_cnt_r <= 4'd0;
        end else begin
            window_r  <= window_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
        end
    end

    // Registered word outputs; data_out holds between words.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            comma_det_r  <= 1'b0;
            realign_r    <= 1'b0;
        end else begin
            if (emit_s) begin
                data_out_r <= next_window_s;
            end else begin
                data_out_r <= data_out_r;
            end
            data_valid_r <= emit_s;
            comma_det_r  <= emit_s & is_comma_s;
            realign_r    <= realign_s;
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign comma_det  = comma_det_r;
    assign realign    = realign_r;
    assign locked     = (state_r == LOCKED);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: table of aligned words plus hand-written corner sequences,
// with emitted words checked against a scoreboard queue.
module tb_deserializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       valid_in;
    logic       lock_clr;
    logic [9:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       comma_det;
    logic       realign;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [9:0] data;
        logic       comma;
        logic       realign;
    } exp_t;

    typedef struct {
        logic [9:0] word;
        int         gap_pos;
        int         gap_len;
        logic       exp_comma;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[7];

    deserializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .serial_in  (serial_in),
        .valid_in   (valid_in),
        .lock_clr   (lock_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .comma_det  (comma_det),
        .realign    (realign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [9:0] d, input logic c, input logic r);
        exp_t e;
        e.data    = d;
        e.comma   = c;
        e.realign = r;
        sb_q.push_back(e);
    endtask

    // Drive bits[0..n-1] LSB-first, one accepted bit per cycle, with an optional valid gap before gap_pos.
    task automatic send_bits(input logic [9:0] bits, input int n, input int gap_pos, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    valid_in = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            serial_in = bits[i];
            valid_in  = 1'b1;
            @(posedge clk);
            #1;
            valid_in  = 1'b0;
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (data_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_valid: got data_out=%0h expected no word at %0t", data_out, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", {22'd0, data_out}, {22'd0, e.data});
                    chk("sb_comma", {31'd0, comma_det}, {31'd0, e.comma});
                    chk("sb_realign", {31'd0, realign}, {31'd0, e.realign});
                end
            end else begin
                chk("idle_pulses", {30'd0, comma_det, realign}, 32'd0);
            end
        end
    end

    initial begin
        vecs[0] = '{word: 10'h2AA, gap_pos: -1, gap_len: 0, exp_comma: 1'b0};
        vecs[1] = '{word: 10'h155, gap_pos: -1, gap_len: 0, exp_comma: 1'b0};
        vecs[2] = '{word: 10'h0F3, gap_pos: 5,  gap_len: 3, exp_comma: 1'b0};
        vecs[3] = '{word: 10'h2AA, gap_pos: -1, gap_len: 0, exp_comma: 1'b0};
        vecs[4] = '{word: 10'h17C, gap_pos: -1, gap_len: 0, exp_comma: 1'b1};
        vecs[5] = '{word: 10'h2AA, gap_pos: 2,  gap_len: 1, exp_comma: 1'b0};
        vecs[6] = '{word: 10'h155, gap_pos: -1, gap_len: 0, exp_comma: 1'b0};

        reset_n   = 1'b0;
        serial_in = 1'b0;
        valid_in  = 1'b0;
        lock_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", {22'd0, data_out}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_comma_det", {31'd0, comma_det}, 32'd0);
        chk("rst_realign", {31'd0, realign}, 32'd0);
        reset_n = 1'b1;

        // Arbitrary non-comma lead-in, then the comma that establishes alignment.
        send_bits(10'b0000010110, 5, -1, 0);
        chk("hunt_locked", {31'd0, locked}, 32'd0);
        push_exp(10'h17C, 1'b1, 1'b0);
        send_bits(10'h17C, 10, -1, 0);
        chk("lock_valid", {31'd0, data_valid}, 32'd1);
        chk("lock_locked", {31'd0, locked}, 32'd1);

        for (int v = 0; v < 7; v++) begin
            push_exp(vecs[v].word, vecs[v].exp_comma, 1'b0);
            send_bits(vecs[v].word, 9, vecs[v].gap_pos, vecs[v].gap_len);
            chk("vec_no_early_valid", {31'd0, data_valid}, 32'd0);
            send_bits(vecs[v].word >> 9, 1, -1, 0);
            chk("vec_valid_latency", {31'd0, data_valid}, 32'd1);
        end

        // lock_clr on bit 6: that bit is dropped and alignment is lost.
        send_bits(10'h2AA, 6, -1, 0);
        serial_in = 1'b0;
        valid_in  = 1'b1;
        lock_clr  = 1'b1;
        @(posedge clk);
        #1;
        lock_clr  = 1'b0;
        valid_in  = 1'b0;
        chk("clr_locked", {31'd0, locked}, 32'd0);
        send_bits(10'h2AA, 10, -1, 0);
        chk("clr_no_valid", {31'd0, data_valid}, 32'd0);
        push_exp(10'h283, 1'b1, 1'b0);
        send_bits(10'h283, 10, -1, 0);
        chk("relock_valid", {31'd0, data_valid}, 32'd1);
        chk("relock_locked", {31'd0, locked}, 32'd1);

        // Comma starting 3 bits off the word grid.
        push_exp(10'h01A, 1'b0, 1'b0);
        send_bits(10'h002, 3, -1, 0);
`ifdef DESER_REALIGN_EN
        push_exp(10'h283, 1'b1, 1'b1);
        send_bits(10'h283, 10, -1, 0);
        chk("offgrid_valid", {31'd0, data_valid}, 32'd1);
        push_exp(10'h155, 1'b0, 1'b0);
        send_bits(10'h155, 10, -1, 0);
`else
        send_bits(10'h283, 10, -1, 0);
        chk("offgrid_valid", {31'd0, data_valid}, 32'd0);
        push_exp(10'h155, 1'b0, 1'b0);
        send_bits(10'h02A, 7, -1, 0);
`endif
        chk("grid_valid", {31'd0, data_valid}, 32'd1);
        chk("grid_locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset in the middle of a word.
        send_bits(10'h2AA, 7, -1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_data_out", {22'd0, data_out}, 32'd0);
        chk("arst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("arst_locked", {31'd0, locked}, 32'd0);
        chk("arst_comma_det", {31'd0, comma_det}, 32'd0);
        chk("arst_realign", {31'd0, realign}, 32'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        send_bits(10'h2AA, 10, -1, 0);
        chk("post_rst_no_valid1", {31'd0, data_valid}, 32'd0);
        send_bits(10'h155, 10, -1, 0);
        chk("post_rst_no_valid2", {31'd0, data_valid}, 32'd0);
        chk("post_rst_locked", {31'd0, locked}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
